// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types, constants and forwarding helper for the pipeline hazard logic
package pipe_pkg;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam int MEM_TIMEOUT_DEFAULT = 255;

  typedef enum logic {
    HCU_IDLE = 1'b0,
    HCU_WAIT = 1'b1
  } hcu_state_t;

  // Newest producer wins: MEM holds a younger result than WB.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic [4:0] rd_mem,
    input logic       reg_write_mem,
    input logic [4:0] rd_wb,
    input logic       reg_write_wb
  );
    if (reg_write_mem && rd_mem != 5'd0 && rd_mem == rs) return FWD_MEM;
    if (reg_write_wb && rd_wb != 5'd0 && rd_wb == rs) return FWD_WB;
    return FWD_REG;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - increment-enable counter that holds at all-ones instead of wrapping
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (inc && count != '1) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_control_unit.sv
// rtl/hazard_control_unit.sv - stall/flush/forwarding control with data-memory wait FSM and watchdog
module hazard_control_unit
  import pipe_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       rs1_id,
  input  logic [4:0]       rs2_id,
  input  logic [4:0]       rs1_ex,
  input  logic [4:0]       rs2_ex,
  input  logic [4:0]       rd_ex,
  input  logic             mem_read_ex,
  input  logic [4:0]       rd_mem,
  input  logic             reg_write_mem,
  input  logic [4:0]       rd_wb,
  input  logic             reg_write_wb,
  input  logic             pc_src_ex,
  input  logic             dmem_req_mem,
  input  logic             dmem_ready,
  output logic             stall_if,
  output logic             stall_id,
  output logic             stall_ex,
  output logic             stall_mem,
  output logic             flush_id,
  output logic             flush_ex,
  output logic             flush_wb,
  output logic [1:0]       fwd_a_ex,
  output logic [1:0]       fwd_b_ex,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count,
  output logic             mem_timeout_err
);

  localparam int WCNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCNT_W-1:0] WAIT_LIMIT = WCNT_W'(MEM_TIMEOUT);

  hcu_state_t        state;
  logic [WCNT_W-1:0] wait_cnt;
  logic [WCNT_W-1:0] wait_cnt_next;
  logic              mem_wait;
  logic              redirect;
  logic              load_use;

  assign wait_cnt_next = (wait_cnt == WAIT_LIMIT) ? wait_cnt : wait_cnt + 1'b1;

  // The first miss cycle stalls from IDLE so the pipeline freezes with zero latency.
  assign mem_wait = (state == HCU_WAIT) || (dmem_req_mem && !dmem_ready);
  assign redirect = pc_src_ex && !mem_wait;
  assign load_use = !mem_wait && !pc_src_ex && mem_read_ex && rd_ex != 5'd0 &&
                    (rd_ex == rs1_id || rd_ex == rs2_id);

  always_comb begin
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    stall_ex  = 1'b0;
    stall_mem = 1'b0;
    flush_id  = 1'b0;
    flush_ex  = 1'b0;
    flush_wb  = 1'b0;
    fwd_a_ex  = FWD_REG;
    fwd_b_ex  = FWD_REG;
    if (!reset) begin
      stall_if  = mem_wait || load_use;
      stall_id  = mem_wait || load_use;
      stall_ex  = mem_wait;
      stall_mem = mem_wait;
      flush_id  = redirect;
      flush_ex  = redirect || load_use;
      flush_wb  = mem_wait;
      fwd_a_ex  = fwd_sel(rs1_ex, rd_mem, reg_write_mem, rd_wb, reg_write_wb);
      fwd_b_ex  = fwd_sel(rs2_ex, rd_mem, reg_write_mem, rd_wb, reg_write_wb);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= HCU_IDLE;
      wait_cnt        <= '0;
      mem_timeout_err <= 1'b0;
    end else begin
      case (state)
        HCU_IDLE: begin
          if (dmem_req_mem && !dmem_ready) begin
            state    <= HCU_WAIT;
            wait_cnt <= '0;
          end
        end
        HCU_WAIT: begin
          wait_cnt <= wait_cnt_next;
          // Watchdog only reports; the access is left to complete on its own.
          if (wait_cnt_next == WAIT_LIMIT) mem_timeout_err <= 1'b1;
          if (dmem_ready) state <= HCU_IDLE;
        end
        default: state <= HCU_IDLE;
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_if),
    .count (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (flush_id),
    .count (flush_count)
  );

endmodule

// File: tb/tb_hazard_control_unit.sv
// tb/tb_hazard_control_unit.sv - randomized and directed checks of hazard_control_unit against a reference model
module tb_hazard_control_unit;

  localparam int CW  = 3;
  localparam int TO  = 4;
  localparam int SAT = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset;
  logic [4:0] rs1_id, rs2_id, rs1_ex, rs2_ex, rd_ex, rd_mem, rd_wb;
  logic mem_read_ex, reg_write_mem, reg_write_wb, pc_src_ex, dmem_req_mem, dmem_ready;
  logic stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, flush_wb;
  logic [1:0] fwd_a_ex, fwd_b_ex;
  logic [CW-1:0] stall_cycles, flush_count;
  logic mem_timeout_err;

  int total = 0;
  int bad = 0;

  bit m_wait;
  int m_wcnt;
  bit m_err;
  int m_sc, m_fc;

  hazard_control_unit #(.CNT_W(CW), .MEM_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .rs1_id(rs1_id), .rs2_id(rs2_id), .rs1_ex(rs1_ex), .rs2_ex(rs2_ex),
    .rd_ex(rd_ex), .mem_read_ex(mem_read_ex), .rd_mem(rd_mem), .reg_write_mem(reg_write_mem),
    .rd_wb(rd_wb), .reg_write_wb(reg_write_wb), .pc_src_ex(pc_src_ex),
    .dmem_req_mem(dmem_req_mem), .dmem_ready(dmem_ready),
    .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex), .stall_mem(stall_mem),
    .flush_id(flush_id), .flush_ex(flush_ex), .flush_wb(flush_wb),
    .fwd_a_ex(fwd_a_ex), .fwd_b_ex(fwd_b_ex),
    .stall_cycles(stall_cycles), .flush_count(flush_count), .mem_timeout_err(mem_timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
    if (reg_write_mem && rd_mem != 0 && rd_mem == rs) return 2'b10;
    if (reg_write_wb && rd_wb != 0 && rd_wb == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic idle_inputs();
    {rs1_id, rs2_id, rs1_ex, rs2_ex, rd_ex, rd_mem, rd_wb} = '0;
    {mem_read_ex, reg_write_mem, reg_write_wb, pc_src_ex, dmem_req_mem, dmem_ready} = '0;
  endtask

  task automatic model_clear();
    m_wait = 0; m_wcnt = 0; m_err = 0; m_sc = 0; m_fc = 0;
  endtask

  // Called at a falling edge with inputs settled; checks, then advances one clock.
  task automatic tick();
    bit mw, redir, lu;
    #1;
    mw    = m_wait || (dmem_req_mem && !dmem_ready);
    redir = pc_src_ex && !mw;
    lu    = !mw && !pc_src_ex && mem_read_ex && rd_ex != 0 && (rd_ex == rs1_id || rd_ex == rs2_id);
    chk("stalls", 32'({stall_if, stall_id, stall_ex, stall_mem}), 32'({mw || lu, mw || lu, mw, mw}));
    chk("flushes", 32'({flush_id, flush_ex, flush_wb}), 32'({redir, redir || lu, mw}));
    chk("fwd", 32'({fwd_a_ex, fwd_b_ex}), 32'({ref_fwd(rs1_ex), ref_fwd(rs2_ex)}));
    chk("stall_cycles", 32'(stall_cycles), 32'(m_sc));
    chk("flush_count", 32'(flush_count), 32'(m_fc));
    chk("timeout_err", 32'(mem_timeout_err), 32'(m_err));
    @(posedge clk);
    if (mw || lu) m_sc = (m_sc < SAT) ? m_sc + 1 : SAT;
    if (redir) m_fc = (m_fc < SAT) ? m_fc + 1 : SAT;
    if (m_wait) begin
      m_wcnt = (m_wcnt < TO) ? m_wcnt + 1 : TO;
      if (m_wcnt == TO) m_err = 1;
      if (dmem_ready) m_wait = 0;
    end else if (dmem_req_mem && !dmem_ready) begin
      m_wait = 1;
      m_wcnt = 0;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_ctl", 32'({stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, flush_wb}), 32'd0);
    chk("rst_fwd", 32'({fwd_a_ex, fwd_b_ex}), 32'd0);
    chk("rst_cnt", 32'({stall_cycles, flush_count, mem_timeout_err}), 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_clear();
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    model_clear();
    @(posedge clk);
    @(negedge clk);
    do_reset();

    // Forwarding priority
    rd_mem = 5; reg_write_mem = 1; rd_wb = 5; reg_write_wb = 1; rs1_ex = 5;
    #1 chk("t1_mem_beats_wb", 32'(fwd_a_ex), 32'd2);
    tick();
    rd_mem = 0;
    #1 chk("t1_wb_when_rd0", 32'(fwd_a_ex), 32'd1);
    tick();
    idle_inputs();

    // Load-use: one stall cycle, then the bubble clears it
    mem_read_ex = 1; rd_ex = 7; rs2_id = 7;
    #1 chk("t2_lu", 32'({stall_if, stall_id, flush_ex}), 32'b111);
    tick();
    mem_read_ex = 0; rd_ex = 0;
    #1 chk("t2_after", 32'({stall_if, stall_id, flush_ex}), 32'b000);
    tick();
    mem_read_ex = 1; rd_ex = 0; rs2_id = 0;
    #1 chk("t2_rd0", 32'(stall_if), 32'd0);
    tick();
    idle_inputs();

    // Redirect beats load-use
    do_reset();
    mem_read_ex = 1; rd_ex = 3; rs1_id = 3; pc_src_ex = 1;
    #1 chk("t3_redir", 32'({flush_id, flush_ex, stall_if}), 32'b110);
    tick();
    idle_inputs();
    #1 chk("t3_fcount", 32'(flush_count), 32'd1);
    tick();

    // Memory wait of 4 cycles with a pending redirect held behind it
    do_reset();
    dmem_req_mem = 1; pc_src_ex = 1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("t4_wait", 32'({stall_if, stall_id, stall_ex, stall_mem, flush_wb, flush_id}), 32'b111110);
      tick();
    end
    dmem_ready = 1;
    #1 chk("t4_last", 32'({stall_if, stall_mem, flush_wb, flush_id}), 32'b1110);
    tick();
    dmem_req_mem = 0; dmem_ready = 0;
    #1 chk("t4_release", 32'({stall_if, flush_id, flush_ex}), 32'b011);
    chk("t4_scount", 32'(stall_cycles), 32'd4);
    tick();
    idle_inputs();

    // Watchdog
    do_reset();
    dmem_req_mem = 1;
    for (int i = 0; i < 4; i++) tick();
    chk("t5_before", 32'(mem_timeout_err), 32'd0);
    tick();
    chk("t5_set", 32'(mem_timeout_err), 32'd1);
    for (int i = 0; i < 5; i++) tick();
    dmem_ready = 1;
    tick();
    idle_inputs();
    tick();
    chk("t5_sticky", 32'(mem_timeout_err), 32'd1);
    do_reset();
    #1 chk("t5_cleared", 32'(mem_timeout_err), 32'd0);

    // Counter saturation and reset in the middle of a wait
    mem_read_ex = 1; rd_ex = 9; rs1_id = 9;
    for (int i = 0; i < 10; i++) tick();
    chk("t6_sat", 32'(stall_cycles), 32'd7);
    idle_inputs();
    dmem_req_mem = 1;
    tick();
    tick();
    do_reset();
    dmem_req_mem = 0;
    #1 chk("t6_idle", 32'({stall_if, flush_wb}), 32'd0);
    tick();

    // Randomized traffic with occasional resets
    for (int n = 0; n < 600; n++) begin
      rs1_id = 5'($urandom_range(0, 3)); rs2_id = 5'($urandom_range(0, 3));
      rs1_ex = 5'($urandom_range(0, 3)); rs2_ex = 5'($urandom_range(0, 3));
      rd_ex  = 5'($urandom_range(0, 3)); rd_mem = 5'($urandom_range(0, 3));
      rd_wb  = 5'($urandom_range(0, 3));
      mem_read_ex   = ($urandom_range(0, 1) == 0);
      reg_write_mem = ($urandom_range(0, 1) == 0);
      reg_write_wb  = ($urandom_range(0, 1) == 0);
      pc_src_ex     = ($urandom_range(0, 3) == 0);
      dmem_req_mem  = ($urandom_range(0, 2) == 0);
      dmem_ready    = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 59) == 0) do_reset();
      else tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
